bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 sends bit WIDTH-1 first, 0 sends bit 0 first.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-005 SHALL have port din  input  WIDTH: parallel word to serialize.
REQ-006 SHALL have port din_valid  input  1: din holds a valid word.
REQ-007 SHALL have port din_ready  output  1: the block accepts din this cycle.
REQ-008 SHALL have port shift_en  input  1: advance one bit this cycle; 0 stalls the block.
REQ-009 SHALL have port x  output  1: serial bit feeding the sequence detector input.
REQ-010 SHALL have port x_valid  output  1: x carries a payload bit this cycle.
REQ-011 SHALL have port word_done  output  1: one-cycle pulse marking the last bit of a word.

Function
REQ-012 SHALL accept a word only on a cycle where din_valid=1 and din_ready=1.
REQ-013 SHALL implement a state machine with two states, IDLE and SHIFT.
REQ-014 SHALL, in IDLE, drive din_ready=1, x=0 and x_valid=0.
REQ-015 SHALL move IDLE->SHIFT when a word is accepted: load the shift register and set the bit counter to 0.
REQ-016 SHALL, in SHIFT, drive x from the registered shift-register head (MSB or LSB per MSB_FIRST) with x_valid=1.
REQ-017 SHALL present the first bit of a word on the cycle after acceptance (latency 1 cycle).
REQ-018 SHALL, in SHIFT with shift_en=1, shift one position and increment the counter; with shift_en=0, hold x, the counter and the state unchanged.
REQ-019 SHALL assert word_done combinationally when in SHIFT, counter=WIDTH-1 and shift_en=1.
REQ-020 SHALL fill the shift-register positions vacated by shifting with 0.
REQ-021 SHALL, on the word_done cycle, go to IDLE unless a next word is available (see REQ-025).
REQ-022 SHALL ignore din and din_valid whenever din_ready=0; upstream keeps din stable until accepted.
REQ-023 SHALL not react to din_valid toggling while in SHIFT: no state, counter or data change.

Reset
REQ-024 SHALL, when rst=1 at a clock edge, force state=IDLE, counter=0, shift register=0 and holding buffer empty, overriding any word in flight; outputs are then x=0, x_valid=0, word_done=0, din_ready=1 on the following cycle.

Configuration
REQ-025 SHALL, with macro BIT_SERIALIZER_SKID_EN defined, add a one-entry holding buffer:
- din_ready = buffer empty, in any state.
- A word accepted during SHIFT is stored in the buffer.
- On the word_done cycle a buffered word loads directly into the shift register; the block stays in SHIFT with no x_valid gap.
- Acceptance on the same word_done cycle as the reload is allowed.
REQ-026 SHALL, without BIT_SERIALIZER_SKID_EN, drive din_ready=1 only in IDLE, giving at least one x_valid=0 cycle between consecutive words.

Structure
REQ-027 SHALL take state encodings (IDLE=1'b0, SHIFT=1'b1) and the counter-width function (clog2 of WIDTH) from shared package seq_pkg, which the sequence detector family also uses.
REQ-028 SHALL place the holding buffer in sub-module ser_skid_buf, instantiated only when BIT_SERIALIZER_SKID_EN is defined; everything else stays flat.

Verification
REQ-029 SHALL verify: WIDTH=8, MSB_FIRST=1, din=8'hA5 accepted, shift_en=1 held -> x=1,0,1,0,0,1,0,1 over cycles 1..8 after acceptance, word_done on cycle 8, IDLE on cycle 9.
REQ-030 SHALL verify: MSB_FIRST=0, din=8'h01 -> x=1 then seven 0s; a downstream 101 detector fed from x sees no detection.
REQ-031 SHALL verify: din=8'hA5 with shift_en=0 on cycles 3-4 -> x holds 1 during the stall, the full sequence is preserved and word_done moves to cycle 10.
REQ-032 SHALL verify: rst=1 on cycle 4 of a word -> next cycle x_valid=0, din_ready=1, no word_done; a new word 8'hFF then serializes cleanly.
REQ-033 SHALL verify, with BIT_SERIALIZER_SKID_EN: back-to-back 8'hA5, 8'h5A -> 16 contiguous x_valid cycles and word_done on cycles 8 and 16; without the macro, exactly one x_valid=0 cycle between the two words.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared state encodings and counter sizing for the serializer / sequence-detector family.
// Pure constants and a sizing helper; no timing or flow control of its own.
package seq_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   // Bit-counter width for a WIDTH-bit word; never less than one bit.
   function automatic int cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/ser_skid_buf.sv
// One-entry holding register for the next serializer word; write-to-full latency 1 cycle.
// No backpressure of its own: the owner must only write while empty (full gates din_ready).
module ser_skid_buf #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_vld,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_vld,
   output logic             full,
   output logic [WIDTH-1:0] rd_dat
);

   always_ff @(posedge clk) begin
      if (rst) begin
         full   <= 1'b0;
         rd_dat <= '0;
      end else if (wr_vld) begin
         full   <= 1'b1;
         rd_dat <= wr_dat;
      end else if (rd_vld) begin
         full   <= 1'b0;
      end
   end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the sequence detector; first bit 1 cycle after accept, shift_en=0 stalls.
// BIT_SERIALIZER_SKID_EN adds a one-word holding buffer for gapless back-to-back words; else din_ready only in IDLE.
module bit_serializer
   import seq_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   input  logic             shift_en,
   output logic             x,
   output logic             x_valid,
   output logic             word_done
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] sreg_shifted;
   logic [WIDTH-1:0] next_word;
   logic             in_shift;
   logic             head;
   logic             accept;
   logic             reload;

   assign in_shift     = (state == ST_SHIFT);
   assign head         = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
   assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};

   assign x         = in_shift & head;
   assign x_valid   = in_shift;
   assign word_done = in_shift & shift_en & (cnt == CNT_LAST);
   assign accept    = din_valid & din_ready;

`ifdef BIT_SERIALIZER_SKID_EN
   logic             buf_full;
   logic [WIDTH-1:0] buf_dat;

   // A word arriving on the word_done cycle bypasses the buffer and reloads directly.
   ser_skid_buf #(.WIDTH(WIDTH)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .wr_vld (accept & in_shift & ~word_done),
      .wr_dat (din),
      .rd_vld (word_done & buf_full),
      .full   (buf_full),
      .rd_dat (buf_dat)
   );

   assign din_ready = ~buf_full;
   assign reload    = buf_full | accept;
   assign next_word = buf_full ? buf_dat : din;
`else
   assign din_ready = ~in_shift;
   assign reload    = 1'b0;
   assign next_word = din;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         sreg  <= '0;
      end else if (state == ST_IDLE) begin
         if (accept) begin
            state <= ST_SHIFT;
            cnt   <= '0;
            sreg  <= din;
         end
      end else if (shift_en) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (reload) begin
               sreg <= next_word;
            end else begin
               sreg  <= sreg_shifted;
               state <= ST_IDLE;
            end
         end else begin
            sreg <= sreg_shifted;
            cnt  <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: MSB-first and LSB-first instances, directed words.
// Build with BIT_SERIALIZER_SKID_EN defined to exercise the gapless back-to-back path.
module tb_bit_serializer;

   typedef struct packed {
      logic x;
      logic wd;
   } exp_t;

   logic       clk         = 1'b0;
   logic       rst         = 1'b1;
   logic       shift_en    = 1'b1;
   logic [7:0] din         = '0;
   logic       din_valid   = 1'b0;
   logic       din_valid_l = 1'b0;
   logic       din_ready, x, x_valid, word_done;
   logic       din_ready_l, x_l, x_valid_l, word_done_l;

   exp_t q_m[$];
   exp_t q_l[$];
   exp_t em, el;
   int   n_vec   = 0;
   int   n_bad   = 0;
   int   det_cnt = 0;
   int   seen_l  = 0;
   logic [1:0] hist_l = '0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .shift_en(shift_en), .x(x), .x_valid(x_valid), .word_done(word_done)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid_l), .din_ready(din_ready_l),
      .shift_en(shift_en), .x(x_l), .x_valid(x_valid_l), .word_done(word_done_l)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // bits[n-1] is the first serial bit; wd_at is the 1-based position of word_done (0 = none)
   task automatic push_seq(input bit lsb_inst, input logic [15:0] bits, input int n, input int wd_at);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.x  = bits[n-1-i];
         e.wd = ((i + 1) == wd_at);
         if (lsb_inst) q_l.push_back(e);
         else          q_m.push_back(e);
      end
   endtask

   task automatic idle_check(input string tag);
      @(negedge clk);
      chk({tag, "_x_valid"}, x_valid, 1'b0);
      chk({tag, "_din_ready"}, din_ready, 1'b1);
      chk({tag, "_x"}, x, 1'b0);
      chk({tag, "_sb_drained"}, q_m.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitors: one expected record per x_valid cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (x_valid) begin
            if (q_m.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL msb_extra_bit: got x_valid=1, expected no payload");
            end else begin
               em = q_m.pop_front();
               chk("msb_x", x, em.x);
               chk("msb_word_done", word_done, em.wd);
            end
         end else begin
            chk("msb_wd_without_valid", word_done, 1'b0);
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && x_valid_l) begin
         if (q_l.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL lsb_extra_bit: got x_valid=1, expected no payload");
         end else begin
            el = q_l.pop_front();
            chk("lsb_x", x_l, el.x);
            chk("lsb_word_done", word_done_l, el.wd);
         end
         // Reference 101 detector (overlapping) driven from the LSB-first stream
         if (seen_l >= 2 && {hist_l, x_l} == 3'b101) det_cnt++;
         hist_l = {hist_l[0], x_l};
         seen_l++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected run to finish");
      n_bad++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      logic xv_h[30];
      logic wd_h[30];
      logic acc;
      int   sent, first, last, ones, gaps, wd_total;

      // Reset state
      rst = 1'b1;
      repeat (2) tick;
      @(negedge clk);
      chk("rst_din_ready", din_ready, 1'b1);
      chk("rst_x_valid", x_valid, 1'b0);
      chk("rst_x", x, 1'b0);
      chk("rst_word_done", word_done, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // A5 MSB-first, shift_en held: 1,0,1,0,0,1,0,1, word_done on cycle 8, idle on 9
      din = 8'hA5;
      din_valid = 1'b1;
      push_seq(1'b0, 16'h00A5, 8, 8);
      tick;
      din_valid = 1'b0;
`ifndef BIT_SERIALIZER_SKID_EN
      // din_valid toggling mid-word must not disturb the word in flight
      tick;
      din = 8'h3C;
      din_valid = 1'b1;
      tick;
      din_valid = 1'b0;
      din = 8'h00;
      repeat (6) tick;
`else
      repeat (8) tick;
`endif
      idle_check("t1_idle");

      // 01 LSB-first: 1 then seven 0s, no 101 detection
      din = 8'h01;
      din_valid_l = 1'b1;
      push_seq(1'b1, 16'h0080, 8, 8);
      tick;
      din_valid_l = 1'b0;
      repeat (8) tick;
      @(negedge clk);
      chk("t2_lsb_x_valid", x_valid_l, 1'b0);
      chk("t2_lsb_drained", q_l.size(), 0);
      chk("t2_lsb_bits_seen", seen_l, 8);
      chk("t2_det_101", det_cnt, 0);
      @(posedge clk);
      #1;

      // A5 with stall on cycles 3-4: 1,0,1,1,1,0,0,1,0,1, word_done on cycle 10
      din = 8'hA5;
      din_valid = 1'b1;
      push_seq(1'b0, 16'h02E5, 10, 10);
      tick;
      din_valid = 1'b0;
      tick;
      tick;
      shift_en = 1'b0;
      tick;
      tick;
      shift_en = 1'b1;
      repeat (6) tick;
      idle_check("t3_idle");

      // Reset on cycle 4 of a word, then FF serializes cleanly
      din = 8'hA5;
      din_valid = 1'b1;
      push_seq(1'b0, 16'h0005, 3, 0);
      tick;
      din_valid = 1'b0;
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      @(negedge clk);
      chk("t4_word_done", word_done, 1'b0);
      @(posedge clk);
      #1;
      idle_check("t4_after_rst");
      din = 8'hFF;
      din_valid = 1'b1;
      push_seq(1'b0, 16'h00FF, 8, 8);
      tick;
      din_valid = 1'b0;
      repeat (8) tick;
      idle_check("t4_ff_idle");

      // Back-to-back A5, 5A
      din = 8'hA5;
      din_valid = 1'b1;
      push_seq(1'b0, 16'h00A5, 8, 8);
      push_seq(1'b0, 16'h005A, 8, 8);
      sent = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         xv_h[c] = x_valid;
         wd_h[c] = word_done;
         acc = din_valid & din_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            sent++;
            if (sent == 1) din = 8'h5A;
            else begin
               din_valid = 1'b0;
               din = 8'h00;
            end
         end
      end
      first = 0;
      last = 0;
      ones = 0;
      wd_total = 0;
      for (int c = 29; c >= 0; c--) if (xv_h[c]) first = c;
      for (int c = 0; c < 30; c++) begin
         if (xv_h[c]) begin
            ones++;
            last = c;
         end
         if (wd_h[c]) wd_total++;
      end
      gaps = (last - first + 1) - ones;
      chk("t5_words_accepted", sent, 2);
      chk("t5_first_valid_cycle", first, 1);
      chk("t5_x_valid_cycles", ones, 16);
      chk("t5_word_done_pulses", wd_total, 2);
      chk("t5_wd_first_word", wd_h[first+7], 1'b1);
`ifdef BIT_SERIALIZER_SKID_EN
      chk("t5_gap_cycles", gaps, 0);
      chk("t5_wd_second_word", wd_h[first+15], 1'b1);
`else
      chk("t5_gap_cycles", gaps, 1);
      chk("t5_wd_second_word", wd_h[first+16], 1'b1);
`endif
      idle_check("t5_idle");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
